// File: rtl/alu_serial.sv
// Bit-serial ALU (AND/OR/ADD/SUB/NOR/SLT) processing SLICE bits per clock; result after N=WIDTH/SLICE cycles.
// Valid/ready both sides; result held in DONE until out_ready. ALU_SERIAL_FAST_LOGIC_EN: logic ops finish in 1 cycle.
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Ainvert,
   input  logic             Binvert,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             c_out,
   output logic             overflow
);

   localparam int N  = WIDTH / SLICE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic             alive;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic [1:0]       op_r;
   logic             carry;
   logic [KW-1:0]    k;
   logic             cout_r, ovf_r, msb_r;

   logic [WIDTH-1:0] a_in, b_in, final_res;
   logic [SLICE-1:0] a_s, b_s, sum_s, slice_res;
   logic [SLICE:0]   cy;
   logic             accept, last, done;

   assign a_in   = Ainvert ? ~a : a;
   assign b_in   = Binvert ? ~b : b;
   assign accept = in_valid && in_ready;
   assign last   = (k == KW'(N - 1));
   assign a_s    = a_r[int'(k)*SLICE +: SLICE];
   assign b_s    = b_r[int'(k)*SLICE +: SLICE];

   // Ripple through the slice; cy[SLICE-1] is the carry into the slice's top bit.
   always_comb begin
      cy    = '0;
      sum_s = '0;
      cy[0] = carry;
      for (int i = 0; i < SLICE; i++) begin
         sum_s[i]  = a_s[i] ^ b_s[i] ^ cy[i];
         cy[i+1]   = (a_s[i] & b_s[i]) | (cy[i] & (a_s[i] ^ b_s[i]));
      end
   end

   always_comb begin
      slice_res = sum_s;
      case (op_r)
         2'b00:   slice_res = a_s & b_s;
         2'b01:   slice_res = a_s | b_s;
         default: slice_res = sum_s;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef ALU_SERIAL_FAST_LOGIC_EN
               state_nxt = op[1] ? BUSY : DONE;
`else
               state_nxt = BUSY;
`endif
            end
         end
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         res_r  <= '0;
         op_r   <= '0;
         carry  <= 1'b0;
         k      <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         msb_r  <= 1'b0;
      end else if (accept) begin
         a_r    <= a_in;
         b_r    <= b_in;
         op_r   <= op;
         carry  <= Binvert & ~Ainvert;
         k      <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         msb_r  <= 1'b0;
`ifdef ALU_SERIAL_FAST_LOGIC_EN
         res_r  <= op[0] ? (a_in | b_in) : (a_in & b_in);
`else
         res_r  <= '0;
`endif
      end else if (state == BUSY) begin
         res_r[int'(k)*SLICE +: SLICE] <= slice_res;
         carry <= cy[SLICE];
         if (last) begin
            cout_r <= cy[SLICE];
            ovf_r  <= cy[SLICE] ^ cy[SLICE-1];
            msb_r  <= sum_s[SLICE-1];
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   // Outputs are forced to zero outside DONE so no partial result is ever visible.
   assign done      = (state == DONE);
   assign final_res = (op_r == 2'b11) ? {{(WIDTH-1){1'b0}}, msb_r ^ ovf_r} : res_r;
   assign in_ready  = (state == IDLE) && alive;
   assign out_valid = done;
   assign result    = done ? final_res : '0;
   assign zero      = done && (final_res == '0);
   assign c_out     = done && op_r[1] && cout_r;
   assign overflow  = done && op_r[1] && ovf_r;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial at WIDTH=32, SLICE=4.
module tb_alu_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] a, b, result;
   logic        Ainvert, Binvert;
   logic [1:0]  op;
   logic        out_valid, out_ready;
   logic        zero, c_out, overflow;

   int checks = 0;
   int errors = 0;

   int          o_lat;
   logic [31:0] o_res;
   logic        o_zero, o_cout, o_ovf;

`ifdef ALU_SERIAL_FAST_LOGIC_EN
   localparam int LOGIC_LAT = 1;
`else
   localparam int LOGIC_LAT = 8;
`endif

   alu_serial #(.WIDTH(32), .SLICE(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .Ainvert(Ainvert), .Binvert(Binvert), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .c_out(c_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Issues one op, keeps in_valid high with junk operands while busy, captures outputs in DONE, consumes.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ai,
                         input logic bi, input logic [1:0] top);
      int n;
      @(negedge clk);
      a = ta; b = tb_; Ainvert = ai; Binvert = bi; op = top; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_wait in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      a = 32'hDEADBEEF; b = 32'h13572468; op = ~top; Ainvert = ~ai; Binvert = ~bi;
      o_lat = 0;
      do begin
         @(posedge clk);
         o_lat++;
         @(negedge clk);
      end while (!out_valid && o_lat < 40);
      in_valid = 1'b0;
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL done_wait out_valid=%b required 1", out_valid);
      end
      o_res = result; o_zero = zero; o_cout = c_out; o_ovf = overflow;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; Ainvert = 1'b0; Binvert = 1'b0; op = 2'b00;
      #2 rst_n = 1'b0;
      #15;
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 32'h0)   begin errors++; $display("FAIL rst_result got %h exp 0", result); end
      checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL rst_zero got %b exp 0", zero); end
      checks++; if (c_out !== 1'b0)     begin errors++; $display("FAIL rst_c_out got %b exp 0", c_out); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add;
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 2'b10);
      checks++; if (o_lat !== 8)            begin errors++; $display("FAIL add_latency got %0d exp 8", o_lat); end
      checks++; if (o_res !== 32'h80000000) begin errors++; $display("FAIL add_result got %h exp 80000000", o_res); end
      checks++; if (o_ovf !== 1'b1)         begin errors++; $display("FAIL add_overflow got %b exp 1", o_ovf); end
      checks++; if (o_cout !== 1'b0)        begin errors++; $display("FAIL add_c_out got %b exp 0", o_cout); end
      checks++; if (o_zero !== 1'b0)        begin errors++; $display("FAIL add_zero got %b exp 0", o_zero); end
   endtask

   task automatic test_sub;
      run_op(32'd5, 32'd5, 1'b0, 1'b1, 2'b10);
      checks++; if (o_res !== 32'h0)  begin errors++; $display("FAIL sub_result got %h exp 0", o_res); end
      checks++; if (o_zero !== 1'b1)  begin errors++; $display("FAIL sub_zero got %b exp 1", o_zero); end
      checks++; if (o_cout !== 1'b1)  begin errors++; $display("FAIL sub_c_out got %b exp 1", o_cout); end
      checks++; if (o_ovf !== 1'b0)   begin errors++; $display("FAIL sub_overflow got %b exp 0", o_ovf); end
      run_op(32'd3, 32'd10, 1'b0, 1'b1, 2'b10);
      checks++; if (o_res !== 32'hFFFFFFF9) begin errors++; $display("FAIL sub_neg_result got %h exp fffffff9", o_res); end
      checks++; if (o_cout !== 1'b0)        begin errors++; $display("FAIL sub_neg_c_out got %b exp 0", o_cout); end
   endtask

   task automatic test_slt;
      run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 2'b11);
      checks++; if (o_res !== 32'h1) begin errors++; $display("FAIL slt_neg_result got %h exp 1", o_res); end
      checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL slt_neg_zero got %b exp 0", o_zero); end
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b11);
      checks++; if (o_res !== 32'h0) begin errors++; $display("FAIL slt_ovf_result got %h exp 0", o_res); end
      checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL slt_ovf_zero got %b exp 1", o_zero); end
      run_op(32'd2, 32'd9, 1'b0, 1'b1, 2'b11);
      checks++; if (o_res !== 32'h1) begin errors++; $display("FAIL slt_pos_result got %h exp 1", o_res); end
   endtask

   task automatic test_logic;
      run_op(32'hF0F0F0F0, 32'h0F0F0000, 1'b1, 1'b1, 2'b00);
      checks++; if (o_lat !== LOGIC_LAT)    begin errors++; $display("FAIL nor_latency got %0d exp %0d", o_lat, LOGIC_LAT); end
      checks++; if (o_res !== 32'h00000F0F) begin errors++; $display("FAIL nor_result got %h exp 00000f0f", o_res); end
      checks++; if (o_cout !== 1'b0)        begin errors++; $display("FAIL nor_c_out got %b exp 0", o_cout); end
      checks++; if (o_ovf !== 1'b0)         begin errors++; $display("FAIL nor_overflow got %b exp 0", o_ovf); end
      run_op(32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 2'b00);
      checks++; if (o_res !== 32'h0F000F00) begin errors++; $display("FAIL and_result got %h exp 0f000f00", o_res); end
      run_op(32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 2'b01);
      checks++; if (o_res !== 32'hFFF0FFF0) begin errors++; $display("FAIL or_result got %h exp fff0fff0", o_res); end
      run_op(32'hFFFF0000, 32'hFF00FF00, 1'b1, 1'b1, 2'b01);
      checks++; if (o_res !== 32'h00FFFFFF) begin errors++; $display("FAIL nand_result got %h exp 00ffffff", o_res); end
      run_op(32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 2'b00);
      checks++; if (o_zero !== 1'b1)        begin errors++; $display("FAIL and_zero got %b exp 1", o_zero); end
   endtask

   task automatic test_backpressure;
      int n;
      @(negedge clk);
      a = 32'h10; b = 32'h20; Ainvert = 1'b0; Binvert = 1'b0; op = 2'b10; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      checks++; if (!out_valid) begin errors++; $display("FAIL bp_done_wait out_valid=%b required 1", out_valid); end
      a = 32'h12340000; b = 32'h00005678; op = 2'b01; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL bp_hold_valid got %b exp 1", out_valid); end
         checks++; if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_hold_in_ready got %b exp 0", in_ready); end
         checks++; if (result !== 32'h30)    begin errors++; $display("FAIL bp_hold_result got %h exp 30", result); end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      o_lat = 0;
      do begin
         @(posedge clk);
         o_lat++;
         @(negedge clk);
      end while (!out_valid && o_lat < 40);
      checks++; if (o_lat !== LOGIC_LAT)     begin errors++; $display("FAIL bp_next_latency got %0d exp %0d", o_lat, LOGIC_LAT); end
      checks++; if (result !== 32'h12345678) begin errors++; $display("FAIL bp_next_result got %h exp 12345678", result); end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset_abort;
      int n;
      @(negedge clk);
      a = 32'h7FFFFFFF; b = 32'h1; Ainvert = 1'b0; Binvert = 1'b0; op = 2'b10; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 32'h0)   begin errors++; $display("FAIL abort_result got %h exp 0", result); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL abort_overflow got %b exp 0", overflow); end
      repeat (8) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_held_valid got %b exp 0", out_valid); end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL abort_release_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_release_valid got %b exp 0", out_valid); end
      run_op(32'd3, 32'd4, 1'b0, 1'b0, 2'b10);
      checks++; if (o_res !== 32'd7) begin errors++; $display("FAIL abort_fresh_add got %h exp 7", o_res); end
      checks++; if (o_lat !== 8)     begin errors++; $display("FAIL abort_fresh_latency got %0d exp 8", o_lat); end
   endtask

   task automatic test_back_to_back;
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 2'b10);
      checks++; if (o_res !== 32'h0)  begin errors++; $display("FAIL b2b_wrap_result got %h exp 0", o_res); end
      checks++; if (o_cout !== 1'b1)  begin errors++; $display("FAIL b2b_wrap_c_out got %b exp 1", o_cout); end
      checks++; if (o_ovf !== 1'b0)   begin errors++; $display("FAIL b2b_wrap_overflow got %b exp 0", o_ovf); end
      run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 2'b10);
      checks++; if (o_res !== 32'h23456789) begin errors++; $display("FAIL b2b_add_result got %h exp 23456789", o_res); end
      checks++; if (o_cout !== 1'b0)        begin errors++; $display("FAIL b2b_add_c_out got %b exp 0", o_cout); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_slt();
      test_logic();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
